// File: rtl/r22sdf_frame_ctrl_pkg.sv
// Shared types and helpers for the radix-2^2 SDF FFT stream sequencer.
package r22sdf_frame_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAD, DRAIN} ctrl_state_t;

  // Core latency in enabled cycles: one frame minus one sample.
  function automatic int lat_of(input int stg);
    return (1 << (2 * stg)) - 1;
  endfunction

endpackage

// File: rtl/r22sdf_bitrev.sv
// Combinational bit reverse; maps the core's bit-reversed output order to natural bins.
module r22sdf_bitrev #(
  parameter int W = 4
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  for (genvar i = 0; i < W; i++) begin : g_rev
    assign dout[i] = din[W-1-i];
  end

endmodule

// File: rtl/r22sdf_frame_ctrl.sv
// Stream sequencer for the R2^2 SDF FFT core: input handshake, pipeline fill
// tracking, output valid/last/bin with backpressure, and flush pad/drain.
module r22sdf_frame_ctrl
  import r22sdf_frame_ctrl_pkg::*;
#(
  parameter int STG = 3,
  parameter int LAT = lat_of(STG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             flush,
  input  logic             cfg_we,
  input  logic             cfg_scale,
  input  logic             cfg_inv,
  output logic             fft_en,
  output logic             fft_rst,
  output logic             fft_sync,
  output logic             fft_scale,
  output logic             fft_inv,
  output logic             fft_zero,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [2*STG-1:0] m_bin,
  output logic             busy
);

  localparam int IW = 2 * STG;
  localparam int FW = $clog2(LAT + 1);
  localparam logic [IW-1:0] LAST_IDX = {IW{1'b1}};
  localparam logic [FW-1:0] LAT_F    = FW'(LAT);

  ctrl_state_t   state, state_nxt;
  logic [IW-1:0] in_idx, out_idx, in_idx_nxt;
  logic [FW-1:0] fill, fill_nxt, drain_cnt;
  logic          flush_pend, flush_pend_nxt;
  logic          cfg_scale_r, cfg_inv_r;
  logic          cand, go, flush_req;

  always_comb begin
    cand    = 1'b0;
    fft_zero = 1'b0;
    fft_rst = 1'b0;
    case (state)
      IDLE:       fft_rst = 1'b1;
      RUN:        cand    = s_valid;
      PAD, DRAIN: begin cand = 1'b1; fft_zero = 1'b1; end
      default:    fft_rst = 1'b1;
    endcase
  end

  // m_valid deliberately ignores m_ready; the stall lands on fft_en instead.
  assign m_valid   = cand & (fill == LAT_F);
  assign go        = ~m_valid | m_ready;
  assign fft_en    = cand & go;
  assign s_ready   = (state == RUN) & go;
  assign fft_sync  = fft_en & (in_idx == LAST_IDX);
  assign m_last    = m_valid & (out_idx == LAST_IDX);
  assign busy      = (state != IDLE);
  assign fft_scale = cfg_scale_r;
  assign fft_inv   = cfg_inv_r;

  r22sdf_bitrev #(.W(IW)) u_bitrev (.din(out_idx), .dout(m_bin));

  assign in_idx_nxt = fft_en ? in_idx + 1'b1 : in_idx;
  assign fill_nxt   = (fft_en && fill != LAT_F) ? fill + 1'b1 : fill;
  assign flush_req  = flush | flush_pend;

  always_comb begin
    state_nxt      = state;
    flush_pend_nxt = 1'b0;
    case (state)
      IDLE: if (s_valid) state_nxt = RUN;
      RUN: begin
        // A flush seen while stalled is held until the handshake can move;
        // in_idx is judged after any sample accepted in the same cycle.
        if (flush_req && !go) begin
          flush_pend_nxt = 1'b1;
        end else if (flush_req) begin
          if (in_idx_nxt != '0)    state_nxt = PAD;
          else if (fill_nxt != '0) state_nxt = DRAIN;
          else                     state_nxt = IDLE;
        end
      end
      PAD:   if (fft_en && in_idx == LAST_IDX) state_nxt = DRAIN;
      DRAIN: if (fft_en && drain_cnt == LAT_F - 1'b1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_idx      <= '0;
      out_idx     <= '0;
      fill        <= '0;
      drain_cnt   <= '0;
      flush_pend  <= 1'b0;
      cfg_scale_r <= 1'b0;
      cfg_inv_r   <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_pend <= flush_pend_nxt;
      if (cfg_we) begin
        cfg_scale_r <= cfg_scale;
        cfg_inv_r   <= cfg_inv;
      end
      if (state_nxt == IDLE) begin
        in_idx    <= '0;
        out_idx   <= '0;
        fill      <= '0;
        drain_cnt <= '0;
      end else begin
        in_idx <= in_idx_nxt;
        fill   <= fill_nxt;
        if (m_valid && m_ready) out_idx <= out_idx + 1'b1;
        if (state != DRAIN)     drain_cnt <= '0;
        else if (fft_en)        drain_cnt <= drain_cnt + 1'b1;
      end
    end
  end

endmodule
